// File: rtl/core_dct_trace_arbiter_pkg.sv
// Shared types and field layout for the core DCT trace arbiter.
package core_trace_pkg;
  typedef enum logic [1:0] {RUN, FULL, FLUSH, DONE} state_e;

  localparam int DCT_W      = 30;
  localparam int CNT_W      = 4;
  localparam int WD_BUF_LSB = 0;
  localparam int WD_CNT_LSB = DCT_W;
  localparam int WD_ID_LSB  = DCT_W + CNT_W;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [DCT_W-1:0] dct;
  } slot_t;
endpackage

// File: rtl/core_dct_trace_arbiter_if.sv
// Core request bus plus trace memory write port of the trace arbiter.
interface core_dct_trace_arbiter_if #(
  parameter int NCORES = 6,
  parameter int IDW    = 3,
  parameter int AW     = 10
);
  import core_trace_pkg::*;

  logic [NCORES-1:0]       req_valid;
  logic [NCORES-1:0]       req_ready;
  logic [NCORES*DCT_W-1:0] dct_buffer;
  logic [NCORES*CNT_W-1:0] dct_count;
  logic                    tm_write;
  logic [AW-1:0]           tm_addr;
  logic [IDW+CNT_W+DCT_W-1:0] tm_wdata;
  logic                    tm_ready;

  modport slave (
    input  req_valid, dct_buffer, dct_count, tm_ready,
    output req_ready, tm_write, tm_addr, tm_wdata
  );
  modport master (
    output req_valid, dct_buffer, dct_count, tm_ready,
    input  req_ready, tm_write, tm_addr, tm_wdata
  );
endinterface

// File: rtl/core_dct_trace_arbiter_rr_arbiter.sv
// Round-robin picker: first set request at or after the pointer wins.
module rr_arbiter #(
  parameter int N  = 6,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  import core_trace_pkg::*;

  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end
endmodule

// File: rtl/core_dct_trace_arbiter.sv
// Per-core one-entry trace slots merged round-robin into one trace memory write port.
module core_dct_trace_arbiter #(
  parameter int NCORES       = 6,
  parameter int IDW          = 3,
  parameter int AW           = 10,
  parameter bit STOP_ON_FULL = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trace_enable,
  input  logic              trace_clear,
  input  logic              test_ending,
  core_dct_trace_arbiter_if.slave bus,
  output logic              tm_wrapped,
  output logic              tm_full,
  output logic [NCORES-1:0] drop_flag,
  output logic              test_has_ended
);
  import core_trace_pkg::*;

  localparam logic [AW-1:0] ADDR_MAX = '1;

  state_e                  state, state_nx;
  slot_t [NCORES-1:0]      slot;
  logic  [NCORES-1:0]      slot_full, req_arb, gnt;
  logic  [IDW-1:0]         ptr, gidx;
  logic                    gany, can_issue, wr_done, stop_now, clr_pend;

  assign wr_done  = bus.tm_write && bus.tm_ready;
  // Last location accepted while stopping: nothing may follow it into the output register.
  assign stop_now = STOP_ON_FULL && wr_done && (bus.tm_addr == ADDR_MAX) && !clr_pend;
  assign can_issue = (state == RUN || state == FLUSH) && !tm_full && !stop_now &&
                     !trace_clear && (!bus.tm_write || bus.tm_ready);
  assign req_arb  = slot_full & {NCORES{can_issue}};

  rr_arbiter #(.N(NCORES), .IW(IDW)) u_rr (
    .req (req_arb),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (gany)
  );

  for (genvar i = 0; i < NCORES; i++) begin : g_lane
    logic [CNT_W-1:0] cnt;
    logic [DCT_W-1:0] dct;
    logic             hs, load, drop_in, drop_held, full_q, flag_q;
    slot_t            data_q;

    assign cnt       = bus.dct_count[CNT_W*i +: CNT_W];
    assign dct       = bus.dct_buffer[DCT_W*i +: DCT_W];
    assign hs        = bus.req_valid[i] && bus.req_ready[i] && trace_enable && (cnt != '0);
    assign load      = hs && (state == RUN) && !trace_clear;
    assign drop_in   = hs && (state == FULL) && !trace_clear;
    assign drop_held = full_q && !trace_clear &&
                       ((state == FULL) || (state == FLUSH && tm_full));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        full_q <= 1'b0;
        data_q <= '0;
        flag_q <= 1'b0;
      end else if (trace_clear) begin
        full_q <= 1'b0;
        flag_q <= 1'b0;
      end else begin
        if (load) begin
          full_q <= 1'b1;
          data_q <= {cnt, dct};
        end else if (gnt[i] || drop_held) begin
          full_q <= 1'b0;
        end
        if (drop_in || drop_held) flag_q <= 1'b1;
      end
    end

    assign slot_full[i] = full_q;
    assign slot[i]      = data_q;
    assign drop_flag[i] = flag_q;
  end

  // Output register holds its word until the memory takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.tm_write <= 1'b0;
      bus.tm_wdata <= '0;
    end else if (gany) begin
      bus.tm_write <= 1'b1;
      bus.tm_wdata <= {gidx, slot[gidx]};
    end else if (wr_done) begin
      bus.tm_write <= 1'b0;
    end
  end

  // A clear during a stalled write keeps the old address until that write lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.tm_addr <= '0;
      tm_wrapped  <= 1'b0;
      tm_full     <= 1'b0;
      clr_pend    <= 1'b0;
      ptr         <= '0;
    end else if (trace_clear) begin
      ptr        <= '0;
      tm_wrapped <= 1'b0;
      tm_full    <= 1'b0;
      clr_pend   <= bus.tm_write && !bus.tm_ready;
      if (!(bus.tm_write && !bus.tm_ready)) bus.tm_addr <= '0;
    end else begin
      if (gany) ptr <= (gidx == IDW'(NCORES-1)) ? '0 : gidx + IDW'(1);
      if (wr_done) begin
        clr_pend <= 1'b0;
        if (clr_pend)                   bus.tm_addr <= '0;
        else if (bus.tm_addr != ADDR_MAX) bus.tm_addr <= bus.tm_addr + AW'(1);
        else if (STOP_ON_FULL)          tm_full <= 1'b1;
        else begin
          bus.tm_addr <= '0;
          tm_wrapped  <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (trace_clear) state_nx = RUN;
    else begin
      case (state)
        RUN:     if (test_ending) state_nx = FLUSH;
                 else if (stop_now) state_nx = FULL;
        FULL:    if (test_ending) state_nx = FLUSH;
        FLUSH:   if (slot_full == '0 && !bus.tm_write) state_nx = DONE;
        DONE:    state_nx = DONE;
        default: state_nx = RUN;
      endcase
    end
  end

  always_comb begin
    test_has_ended = (state == DONE);
    bus.req_ready  = '0;
    case (state)
      RUN:     bus.req_ready = trace_enable ? (~slot_full | gnt) : '1;
      FULL:    bus.req_ready = '1;
      default: bus.req_ready = '0;
    endcase
  end
endmodule

// File: tb/tb_core_dct_trace_arbiter.sv
// Directed bench: default DUT plus two AW=2 variants (wrap and stop) sharing one stimulus.
module tb_core_dct_trace_arbiter;
  import core_trace_pkg::*;

  localparam int N = 6;
  localparam int IDW = 3;

  logic clk = 1'b0;
  logic reset, trace_enable, trace_clear, test_ending, tm_ready;
  logic [N-1:0]       req_valid;
  logic [N*DCT_W-1:0] dct_buffer;
  logic [N*CNT_W-1:0] dct_count;
  logic wrap0, full0, end0, wrap1, full1, end1, wrap2, full2, end2;
  logic [N-1:0] drop0, drop1, drop2;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  core_dct_trace_arbiter_if #(.NCORES(N), .IDW(IDW), .AW(10)) b0 ();
  core_dct_trace_arbiter_if #(.NCORES(N), .IDW(IDW), .AW(2))  b1 ();
  core_dct_trace_arbiter_if #(.NCORES(N), .IDW(IDW), .AW(2))  b2 ();

  assign b0.req_valid = req_valid;  assign b0.dct_buffer = dct_buffer;
  assign b0.dct_count = dct_count;  assign b0.tm_ready   = tm_ready;
  assign b1.req_valid = req_valid;  assign b1.dct_buffer = dct_buffer;
  assign b1.dct_count = dct_count;  assign b1.tm_ready   = tm_ready;
  assign b2.req_valid = req_valid;  assign b2.dct_buffer = dct_buffer;
  assign b2.dct_count = dct_count;  assign b2.tm_ready   = tm_ready;

  core_dct_trace_arbiter #(.NCORES(N), .IDW(IDW), .AW(10), .STOP_ON_FULL(1'b0)) u0 (
    .clk(clk), .reset(reset), .trace_enable(trace_enable), .trace_clear(trace_clear),
    .test_ending(test_ending), .bus(b0), .tm_wrapped(wrap0), .tm_full(full0),
    .drop_flag(drop0), .test_has_ended(end0));
  core_dct_trace_arbiter #(.NCORES(N), .IDW(IDW), .AW(2), .STOP_ON_FULL(1'b0)) u1 (
    .clk(clk), .reset(reset), .trace_enable(trace_enable), .trace_clear(trace_clear),
    .test_ending(test_ending), .bus(b1), .tm_wrapped(wrap1), .tm_full(full1),
    .drop_flag(drop1), .test_has_ended(end1));
  core_dct_trace_arbiter #(.NCORES(N), .IDW(IDW), .AW(2), .STOP_ON_FULL(1'b1)) u2 (
    .clk(clk), .reset(reset), .trace_enable(trace_enable), .trace_clear(trace_clear),
    .test_ending(test_ending), .bus(b2), .tm_wrapped(wrap2), .tm_full(full2),
    .drop_flag(drop2), .test_has_ended(end2));

  function automatic logic [DCT_W-1:0] bufpat(int i);
    return DCT_W'(32'h0ABC_0000 + i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(int i, logic [CNT_W-1:0] c, logic [DCT_W-1:0] b);
    dct_count[CNT_W*i +: CNT_W]  = c;
    dct_buffer[DCT_W*i +: DCT_W] = b;
  endtask

  task automatic apply_reset();
    reset = 1'b1; trace_enable = 1'b1; trace_clear = 1'b0; test_ending = 1'b0;
    tm_ready = 1'b1; req_valid = '0; dct_buffer = '0; dct_count = '0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (b0.tm_write !== 1'b0) begin errors++; $display("FAIL reset_write got=%0b exp=0", b0.tm_write); end
    checks++; if (b0.tm_addr !== 10'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", b0.tm_addr); end
    checks++; if (b0.req_ready !== 6'h3f) begin errors++; $display("FAIL reset_ready got=%h exp=3f", b0.req_ready); end
    checks++; if ({wrap0, full0, end0} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {wrap0, full0, end0}); end
    checks++; if (drop0 !== 6'h00) begin errors++; $display("FAIL reset_drop got=%h exp=00", drop0); end
    checks++; if ({b2.req_ready, full2} !== 7'b1111110) begin errors++; $display("FAIL reset_stop_dut got=%b exp=1111110", {b2.req_ready, full2}); end
  endtask

  task automatic test_single();
    apply_reset();
    set_core(2, 4'd5, 30'h2AAAAAAA);
    req_valid = 6'b000100;
    tick();
    req_valid = '0;
    checks++; if (b0.tm_write !== 1'b0) begin errors++; $display("FAIL single_t1_write got=%0b exp=0", b0.tm_write); end
    tick();
    checks++; if (b0.tm_write !== 1'b1) begin errors++; $display("FAIL single_t2_write got=%0b exp=1", b0.tm_write); end
    checks++; if (b0.tm_addr !== 10'd0) begin errors++; $display("FAIL single_addr got=%0d exp=0", b0.tm_addr); end
    checks++; if (b0.tm_wdata !== {3'd2, 4'd5, 30'h2AAAAAAA}) begin errors++; $display("FAIL single_wdata got=%h exp=%h", b0.tm_wdata, {3'd2, 4'd5, 30'h2AAAAAAA}); end
    tick();
    checks++; if ({b0.tm_write, b0.tm_addr} !== {1'b0, 10'd1}) begin errors++; $display("FAIL single_after got=%b/%0d exp=0/1", b0.tm_write, b0.tm_addr); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < N; i++) set_core(i, CNT_W'(i + 1), bufpat(i));
    req_valid = '1;
    tick();
    for (int k = 0; k < 7; k++) begin
      tick();
      checks++; if (b0.tm_write !== 1'b1) begin errors++; $display("FAIL rr_write k=%0d got=%0b exp=1", k, b0.tm_write); end
      checks++; if (b0.tm_wdata !== {IDW'(k % N), CNT_W'(k % N + 1), bufpat(k % N)}) begin errors++; $display("FAIL rr_wdata k=%0d got=%h exp=%h", k, b0.tm_wdata, {IDW'(k % N), CNT_W'(k % N + 1), bufpat(k % N)}); end
      checks++; if (b0.tm_addr !== 10'(k)) begin errors++; $display("FAIL rr_addr k=%0d got=%0d exp=%0d", k, b0.tm_addr, k); end
    end
    req_valid = '0;
  endtask

  task automatic test_wrap();
    logic [1:0] exp_a [5];
    exp_a = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    apply_reset();
    set_core(0, 4'd1, 30'h15);
    req_valid = 6'b000001;
    for (int j = 1; j <= 6; j++) begin
      tick();
      if (j == 5) req_valid = '0;
      if (j >= 2) begin
        checks++; if (b1.tm_write !== 1'b1) begin errors++; $display("FAIL wrap_write j=%0d got=%0b exp=1", j, b1.tm_write); end
        checks++; if (b1.tm_addr !== exp_a[j-2]) begin errors++; $display("FAIL wrap_addr j=%0d got=%0d exp=%0d", j, b1.tm_addr, exp_a[j-2]); end
        checks++; if (wrap1 !== (j == 6)) begin errors++; $display("FAIL wrap_flag j=%0d got=%0b exp=%0b", j, wrap1, (j == 6)); end
      end
    end
    tick();
    checks++; if ({b1.tm_write, b1.tm_addr} !== {1'b0, 2'd1}) begin errors++; $display("FAIL wrap_end got=%b/%0d exp=0/1", b1.tm_write, b1.tm_addr); end
  endtask

  task automatic test_stop_full();
    int nw;
    nw = 0;
    apply_reset();
    set_core(0, 4'd2, 30'h2A);
    req_valid = 6'b000001;
    for (int j = 1; j <= 10; j++) begin
      tick();
      if (b2.tm_write === 1'b1) nw++;
      if (j >= 2 && j <= 5) begin
        checks++; if ({b2.tm_addr, full2} !== {2'(j - 2), 1'b0}) begin errors++; $display("FAIL stop_addr j=%0d got=%0d/%0b exp=%0d/0", j, b2.tm_addr, full2, j - 2); end
      end
      if (j == 6) begin
        checks++; if ({full2, b2.tm_write} !== 2'b10) begin errors++; $display("FAIL stop_full got=%b exp=10", {full2, b2.tm_write}); end
        checks++; if (b2.req_ready !== 6'h3f) begin errors++; $display("FAIL stop_ready got=%h exp=3f", b2.req_ready); end
        checks++; if (drop2 !== 6'h00) begin errors++; $display("FAIL stop_drop_early got=%h exp=00", drop2); end
      end
      if (j == 7) begin
        checks++; if (drop2 !== 6'h01) begin errors++; $display("FAIL stop_drop got=%h exp=01", drop2); end
        req_valid = '0;
      end
    end
    checks++; if (nw !== 4) begin errors++; $display("FAIL stop_writes got=%0d exp=4", nw); end
    checks++; if (full2 !== 1'b1) begin errors++; $display("FAIL stop_full_held got=%0b exp=1", full2); end
  endtask

  task automatic test_backpressure();
    int ids [7];
    ids = '{0, 1, 1, 1, 1, 2, 3};
    apply_reset();
    for (int i = 0; i < 4; i++) set_core(i, CNT_W'(i + 3), bufpat(i + 8));
    req_valid = 6'b001111;
    tick();
    req_valid = '0;
    for (int k = 0; k < 7; k++) begin
      tick();
      checks++; if (b0.tm_write !== 1'b1) begin errors++; $display("FAIL bp_write k=%0d got=%0b exp=1", k, b0.tm_write); end
      checks++; if (b0.tm_wdata !== {IDW'(ids[k]), CNT_W'(ids[k] + 3), bufpat(ids[k] + 8)}) begin errors++; $display("FAIL bp_wdata k=%0d got=%h exp=%h", k, b0.tm_wdata, {IDW'(ids[k]), CNT_W'(ids[k] + 3), bufpat(ids[k] + 8)}); end
      checks++; if (b0.tm_addr !== 10'(ids[k])) begin errors++; $display("FAIL bp_addr k=%0d got=%0d exp=%0d", k, b0.tm_addr, ids[k]); end
      if (k == 1) tm_ready = 1'b0;
      if (k == 4) tm_ready = 1'b1;
    end
    tick();
    checks++; if ({b0.tm_write, b0.tm_addr} !== {1'b0, 10'd4}) begin errors++; $display("FAIL bp_end got=%b/%0d exp=0/4", b0.tm_write, b0.tm_addr); end
  endtask

  task automatic test_flush();
    logic exp_w [5];
    logic exp_e [5];
    exp_w = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    apply_reset();
    for (int i = 0; i < 3; i++) set_core(i, 4'd7, bufpat(20 + i));
    req_valid = 6'b000111;
    test_ending = 1'b1;
    tick();
    req_valid = '0;
    test_ending = 1'b0;
    #1;
    checks++; if ({b0.req_ready, end0} !== 7'b0) begin errors++; $display("FAIL flush_ready got=%b exp=0000000", {b0.req_ready, end0}); end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (b0.tm_write !== exp_w[k]) begin errors++; $display("FAIL flush_write k=%0d got=%0b exp=%0b", k, b0.tm_write, exp_w[k]); end
      if (k < 3) begin
        checks++; if (b0.tm_wdata[WD_ID_LSB +: IDW] !== IDW'(k)) begin errors++; $display("FAIL flush_id k=%0d got=%0d exp=%0d", k, b0.tm_wdata[WD_ID_LSB +: IDW], k); end
      end
      checks++; if (end0 !== exp_e[k]) begin errors++; $display("FAIL flush_ended k=%0d got=%0b exp=%0b", k, end0, exp_e[k]); end
    end
    checks++; if (b0.tm_addr !== 10'd3) begin errors++; $display("FAIL flush_addr got=%0d exp=3", b0.tm_addr); end
    trace_clear = 1'b1;
    tick();
    trace_clear = 1'b0;
    #1;
    checks++; if ({end0, b0.req_ready, b0.tm_addr} !== {1'b0, 6'h3f, 10'd0}) begin errors++; $display("FAIL clear got=%0b/%h/%0d exp=0/3f/0", end0, b0.req_ready, b0.tm_addr); end
  endtask

  task automatic test_discard();
    apply_reset();
    trace_enable = 1'b0;
    set_core(1, 4'd4, bufpat(1));
    req_valid = 6'b000010;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if ({b0.tm_write, b0.req_ready, drop0} !== {1'b0, 6'h3f, 6'h00}) begin errors++; $display("FAIL disable k=%0d got=%0b/%h/%h exp=0/3f/00", k, b0.tm_write, b0.req_ready, drop0); end
    end
    trace_enable = 1'b1;
    set_core(3, 4'd0, bufpat(3));
    req_valid = 6'b001000;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (b0.tm_write !== 1'b0) begin errors++; $display("FAIL zero_count k=%0d got=%0b exp=0", k, b0.tm_write); end
    end
    set_core(3, 4'd1, bufpat(3));
    tick();
    req_valid = '0;
    tick();
    checks++; if ({b0.tm_write, b0.tm_addr, b0.tm_wdata} !== {1'b1, 10'd0, IDW'(3), 4'd1, bufpat(3)}) begin errors++; $display("FAIL enable_write got=%0b/%0d/%h", b0.tm_write, b0.tm_addr, b0.tm_wdata); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_stop_full();
    test_backpressure();
    test_flush();
    test_discard();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
